pixel_fifo: RTL and testbench
=============================

// Module: pixel_fifo
// PURPOSE
//  Single-clock pixel buffer between the display-plane stage (writer) and the VGA output stage (reader).
//  Absorbs the burstiness of the 80x60 character-plane fetch against the steady pixel drain.
//  Drives the 'full' stall input of the display-plane stage.
//  'full' asserts early by a configurable margin so in-flight fetches still land.
// PARAMETERS
//  DW          8   pixel width (bits) of wr_data/rd_data
//  ADDR_W      5   log2 of storage depth; DEPTH = 2**ADDR_W = 32 entries
//  FULL_MARGIN 2   free entries remaining when 'full' asserts; legal 0..DEPTH-1
// PORTS
//  clk       in   1           single clock; all flops update on posedge clk
//  rst       in   1           asynchronous, active-high reset
//  wr_en     in   1           push wr_data this cycle
//  wr_data   in   DW          pixel from display-plane stage
//  full      out  1           stall to upstream: level >= DEPTH-FULL_MARGIN
//  rd_en     in   1           pop request from VGA stage
//  rd_data   out  DW          registered pixel out
//  rd_valid  out  1           rd_data holds a popped pixel this cycle
//  empty     out  1           level == 0
//  level     out  ADDR_W+1    current occupancy, 0..DEPTH
//  overflow  out  1           sticky: write dropped
//  underrun  out  1           sticky: read with nothing to pop
//  clr_err   in   1           clears both sticky flags
// BEHAVIOUR
//  Reset (async, rst=1): wr_ptr=rd_ptr=0, level=0, rd_data=0, rd_valid=0, overflow=underrun=0.
//   Outputs: empty=1, full=0. RAM contents are don't-care.
//  rd_acc = rd_en & (level!=0).
//  wr_acc = wr_en & ((level<DEPTH) | rd_acc): at level==DEPTH, a simultaneous read frees the slot.
//  Write: on wr_acc, mem[wr_ptr]<=wr_data; wr_ptr increments and wraps mod DEPTH (natural ADDR_W overflow).
//  Read latency 1: on rd_acc, rd_data<=mem[rd_ptr], rd_valid<=1, rd_ptr increments and wraps.
//  rd_en with level==0: rd_valid<=0, rd_data<=0 (black), underrun<=1.
//  No fall-through: a write into an empty FIFO is not readable until the next cycle.
//   Simultaneous rd_en+wr_en at level 0 -> write lands, read underruns.
//  No rd_en: rd_valid<=0; rd_data holds its value.
//  level <= level + wr_acc - rd_acc, computed at ADDR_W+1 bits; never exceeds DEPTH or goes below 0.
//  full and empty are combinational from the registered level only, never from wr_en or rd_en.
//   Upstream samples full on negedge, so full is stable half a cycle after posedge.
//  wr_en & ~wr_acc -> write dropped, pointers and level unchanged, overflow<=1.
//  clr_err clears both sticky flags; a new error in the same cycle wins (flag stays 1).
//  FULL_MARGIN=0 -> full exactly at level==DEPTH.
//  Reset mid-stream discards all buffered pixels; no partial state survives.
// STRUCTURE
//  Shared package display_pkg: PIX_W=8, SCREEN_COLS=80, SCREEN_ROWS=60, PLANE_SIZE=4800 (13'h12C0).
//   The same package also holds the pixel_t typedef.
//  Sub-module dp_ram_sync: DEPTH x DW storage, one write port, one synchronous read port, no reset.
//   Instantiated once.
//  Top holds pointers, the level counter, the acceptance logic, output registers and sticky flags.
// TESTING
//  Fill: 30 writes 0x01..0x1E, no reads -> full rises when level=30; first 30 entries stored.
//   Two further writes land (level=32, overflow=0); a third is dropped (overflow=1, level=32).
//  Drain: after Fill, 32 consecutive rd_en -> rd_data 0x01..0x1E,next two, each one cycle after rd_en.
//   rd_valid high for 32 cycles; empty=1 after the last pop; full drops when level=29.
//  Wrap: 100 pixels streamed with rd_en/wr_en interleaved and level kept 1..5 -> output order exact.
//   Pointers wrap 3 times; no sticky flag is set.
//  At level 32, wr_en+rd_en together -> write accepted, level stays 32, overflow=0.
//   At level 0, wr_en+rd_en together -> rd_valid=0, rd_data=0, underrun=1, level=1.
//  Sticky flags: clr_err alone -> underrun=0. clr_err with a new underrun in the same cycle -> underrun stays 1.
//  Async reset mid-fill (level=17, rst asserted between edges): outputs clear immediately (level=0, empty=1, full=0).
//   The next written pixel is the first read back.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display-pipeline definitions.
// Holds the pixel width, the 80x60 character-plane geometry and the pixel_t type
// used by the display-plane, buffering and VGA output stages.
package display_pkg;

  localparam int unsigned PIX_W       = 8;
  localparam int unsigned SCREEN_COLS = 80;
  localparam int unsigned SCREEN_ROWS = 60;
  // SCREEN_COLS * SCREEN_ROWS character cells
  localparam logic [12:0] PLANE_SIZE  = 13'h12C0;

  typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port synchronous RAM, Depth = 2**AW words of DW bits.
// Ports:
//   clk_i    clock
//   we_i     write enable; wdata_i is stored at waddr_i on the rising edge
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable; rdata_o loads mem[raddr_i] on the rising edge
//   raddr_i  read address
//   rdata_o  registered read data, holds its value while re_i is low
// No reset: contents and rdata_o are undefined until written/read.
// A read and a write to the same address in one cycle returns the old word.
module dp_ram_sync #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_fifo.sv
// Single-clock pixel buffer between the display-plane stage (writer) and the
// VGA output stage (reader). 'full' asserts FULL_MARGIN entries early so that
// fetches already in flight upstream still find room.
// Ports:
//   clk       clock, all flops on the rising edge
//   rst       asynchronous active-high reset
//   wr_en     push wr_data this cycle
//   wr_data   pixel from the display-plane stage
//   full      stall to upstream: level >= DEPTH - FULL_MARGIN
//   rd_en     pop request from the VGA stage
//   rd_data   popped pixel, one cycle after rd_en; black after an underrun
//   rd_valid  rd_data holds a pixel popped this cycle
//   empty     level == 0
//   level     occupancy, 0..DEPTH
//   overflow  sticky: a write was dropped
//   underrun  sticky: a read found nothing to pop
//   clr_err   clears both sticky flags (a new error in the same cycle wins)
module pixel_fifo
  import display_pkg::*;
#(
  parameter int unsigned DW          = PIX_W,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [DW-1:0]   wr_data,
  output logic            full,
  input  logic            rd_en,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            empty,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic            underrun,
  input  logic            clr_err
);

  localparam int unsigned     Depth      = 2**ADDR_W;
  localparam logic [ADDR_W:0] LevelMax   = (ADDR_W+1)'(Depth);
  localparam logic [ADDR_W:0] FullThresh = (ADDR_W+1)'(Depth - FULL_MARGIN);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              rd_valid_q, rd_valid_d;
  // rd_data is forced to black while set (after reset or an underrun)
  logic              rd_zero_q, rd_zero_d;
  logic              overflow_q, overflow_d;
  logic              underrun_q, underrun_d;

  logic              rd_acc, wr_acc;
  logic [DW-1:0]     ram_rdata;

  // At level == Depth a simultaneous pop frees the slot being written
  assign rd_acc = rd_en & (level_q != '0);
  assign wr_acc = wr_en & ((level_q != LevelMax) | rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
    rd_valid_d = rd_acc;
    rd_zero_d  = rd_zero_q;
    overflow_d = (overflow_q & ~clr_err) | (wr_en & ~wr_acc);
    underrun_d = (underrun_q & ~clr_err) | (rd_en & ~rd_acc);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_zero_d = 1'b0;
    end else if (rd_en) begin
      rd_zero_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      rd_zero_q  <= rd_zero_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  dp_ram_sync #(
    .DW (DW),
    .AW (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign rd_data  = rd_zero_q ? '0 : ram_rdata;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign empty    = (level_q == '0);
  assign full     = (level_q >= FullThresh);
  assign overflow = overflow_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pixel_fifo.sv
// Self-checking bench for pixel_fifo: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer.
module tb_pixel_fifo;

  localparam int DEPTH  = 32;
  localparam int MARGIN = 2;

  logic       clk, rst, wr_en, rd_en, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       full, rd_valid, empty, overflow, underrun;
  logic [5:0] level;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents as a queue plus the registered outputs
  byte unsigned mq[$];
  logic [7:0]   m_data;
  logic         m_valid, m_over, m_under;

  pixel_fifo #(
    .DW          (8),
    .ADDR_W      (5),
    .FULL_MARGIN (MARGIN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .underrun (underrun),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_under = 1'b0;
  endtask

  // Advance one clock with the currently driven inputs, update the model,
  // and return 1 time unit after the edge.
  task automatic tick();
    bit racc, wacc;
    @(posedge clk);
    racc = rd_en && (mq.size() != 0);
    wacc = wr_en && ((mq.size() < DEPTH) || racc);
    if (racc) begin
      m_data  = mq.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (rd_en) m_data = 8'h00;
    end
    if (wacc) mq.push_back(wr_data);
    m_over  = (m_over && !clr_err) || (wr_en && !wacc);
    m_under = (m_under && !clr_err) || (rd_en && !racc);
    #1;
  endtask

  task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
  endtask

  task automatic do_reset();
    drive(0, 8'h00, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive(0, 8'h00, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({level, empty, full, rd_valid, rd_data, overflow, underrun} !== {6'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got level=%0d empty=%b full=%b vld=%b data=%h ovf=%b unr=%b required 0 1 0 0 00 0 0",
               level, empty, full, rd_valid, rd_data, overflow, underrun);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 30; i++) begin
      drive(1, 8'(i + 1), 0, 0);
      tick();
      checks++;
      if (level !== 6'(i + 1) || full !== (i + 1 >= 30)) begin
        errors++;
        $display("FAIL fill_level_full[%0d]: got level=%0d full=%b required level=%0d full=%b",
                 i, level, full, i + 1, (i + 1 >= 30));
      end
    end
    drive(1, 8'h1F, 0, 0); tick();
    drive(1, 8'h20, 0, 0); tick();
    checks++;
    if (level !== 6'd32 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_to_depth: got level=%0d ovf=%b full=%b required 32 0 1", level, overflow, full);
    end
    drive(1, 8'h21, 0, 0); tick();
    checks++;
    if (level !== 6'd32 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_drop: got level=%0d ovf=%b required 32 1", level, overflow);
    end
    drive(0, 8'h00, 0, 0);
  endtask

  task automatic test_drain();
    for (int k = 0; k < 32; k++) begin
      drive(0, 8'h00, 1, 0);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(k + 1) || level !== 6'(31 - k) ||
          full !== (31 - k >= 30)) begin
        errors++;
        $display("FAIL drain[%0d]: got vld=%b data=%h level=%0d full=%b required 1 %h %0d %b",
                 k, rd_valid, rd_data, level, full, 8'(k + 1), 31 - k, (31 - k >= 30));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: got empty=%b required 1", empty);
    end
    drive(0, 8'h00, 0, 0);
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h20) begin
      errors++;
      $display("FAIL idle_hold: got vld=%b data=%h required 0 20", rd_valid, rd_data);
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    int lvl;
    drive(0, 8'h00, 0, 1);
    tick();
    while (got < 100 && cyc < 2000) begin
      lvl     = mq.size();
      wr_en   = (sent < 100) && (lvl < 5) && (lvl == 0 || $urandom_range(0, 1) == 1);
      rd_en   = (lvl > 1 || (sent == 100 && lvl > 0)) && (lvl == 5 || $urandom_range(0, 1) == 1);
      wr_data = 8'($urandom);
      clr_err = 1'b0;
      if (wr_en) sent++;
      tick();
      cyc++;
      if (m_valid) got++;
      checks++;
      if (rd_valid !== m_valid || level !== 6'(mq.size()) || (m_valid && rd_data !== m_data)) begin
        errors++;
        $display("FAIL wrap_stream[%0d]: got vld=%b data=%h level=%0d required %b %h %0d",
                 cyc, rd_valid, rd_data, level, m_valid, m_data, mq.size());
      end
    end
    drive(0, 8'h00, 0, 0);
    checks++;
    if (got != 100) begin
      errors++;
      $display("FAIL wrap_count: got %0d pixels required 100", got);
    end
    checks++;
    if (overflow !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL wrap_sticky: got ovf=%b unr=%b required 0 0", overflow, underrun);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, 8'(8'h40 + i), 0, 0);
      tick();
    end
    drive(1, 8'hEE, 1, 0);
    tick();
    checks++;
    if (level !== 6'd32 || overflow !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'h40) begin
      errors++;
      $display("FAIL rw_at_full: got level=%0d ovf=%b vld=%b data=%h required 32 0 1 40",
               level, overflow, rd_valid, rd_data);
    end
    drive(0, 8'h00, 1, 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== m_data) begin
        errors++;
        $display("FAIL rw_full_drain[%0d]: got vld=%b data=%h required 1 %h", i, rd_valid, rd_data, m_data);
      end
    end
    checks++;
    if (rd_data !== 8'hEE || empty !== 1'b1) begin
      errors++;
      $display("FAIL rw_full_last: got data=%h empty=%b required ee 1", rd_data, empty);
    end
    drive(1, 8'h5A, 1, 0);
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || underrun !== 1'b1 || level !== 6'd1) begin
      errors++;
      $display("FAIL rw_at_empty: got vld=%b data=%h unr=%b level=%0d required 0 00 1 1",
               rd_valid, rd_data, underrun, level);
    end
    drive(0, 8'h00, 1, 0);
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A || empty !== 1'b1) begin
      errors++;
      $display("FAIL rw_empty_readback: got vld=%b data=%h empty=%b required 1 5a 1", rd_valid, rd_data, empty);
    end
    drive(0, 8'h00, 0, 0);
  endtask

  task automatic test_sticky();
    drive(0, 8'h00, 0, 1);
    tick();
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: got unr=%b required 0", underrun);
    end
    drive(0, 8'h00, 1, 0);
    tick();
    drive(0, 8'h00, 1, 1);
    tick();
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_new_error: got unr=%b required 1", underrun);
    end
    drive(0, 8'h00, 0, 1);
    tick();
    checks++;
    if (underrun !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_final: got unr=%b ovf=%b required 0 0", underrun, overflow);
    end
    drive(0, 8'h00, 0, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 8'(8'h80 + i), 0, 0);
      tick();
    end
    drive(0, 8'h00, 0, 0);
    checks++;
    if (level !== 6'd17) begin
      errors++;
      $display("FAIL midfill_level: got %0d required 17", level);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (level !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got level=%0d empty=%b full=%b vld=%b required 0 1 0 0",
               level, empty, full, rd_valid);
    end
    rst = 1'b0;
    model_reset();
    drive(1, 8'hA5, 0, 0);
    tick();
    drive(0, 8'h00, 1, 0);
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_first: got vld=%b data=%h empty=%b required 1 a5 1", rd_valid, rd_data, empty);
    end
    drive(0, 8'h00, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      // Alternate write-heavy and read-heavy phases to visit full and empty
      if ((i / 100) % 2 == 0) begin
        wr_en = ($urandom_range(0, 99) < 75);
        rd_en = ($urandom_range(0, 99) < 30);
      end else begin
        wr_en = ($urandom_range(0, 99) < 30);
        rd_en = ($urandom_range(0, 99) < 75);
      end
      wr_data = 8'($urandom);
      clr_err = ($urandom_range(0, 99) < 8);
      tick();
      checks++;
      if (rd_valid !== m_valid || rd_data !== m_data || level !== 6'(mq.size()) ||
          full !== (mq.size() >= DEPTH - MARGIN) || empty !== (mq.size() == 0) ||
          overflow !== m_over || underrun !== m_under) begin
        errors++;
        $display("FAIL random[%0d]: got vld=%b data=%h lvl=%0d full=%b empty=%b ovf=%b unr=%b required %b %h %0d %b %b %b %b",
                 i, rd_valid, rd_data, level, full, empty, overflow, underrun, m_valid, m_data,
                 mq.size(), (mq.size() >= DEPTH - MARGIN), (mq.size() == 0), m_over, m_under);
      end
    end
    drive(0, 8'h00, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_sticky();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
